// File: rtl/binary_to_bcd_seq_if.sv
// Bus between a conversion requester (master) and the binary_to_bcd_seq converter (slave).
// Handshake: i_Start is level-sampled each edge and is accepted only while o_Busy=0; a
// result is valid only in the single cycle o_DV=1 and then holds until the next pulse.
interface binary_to_bcd_seq_if #(
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3
);
  localparam int DIG_W = $clog2(DECIMAL_DIGITS + 1);

  logic [INPUT_WIDTH-1:0]      i_Binary;
  logic                        i_Start;
  logic [DECIMAL_DIGITS*4-1:0] o_BCD;
  logic                        o_Sign;
  logic [DIG_W-1:0]            o_Digits;
  logic                        o_Overflow;
  logic                        o_Busy;
  logic                        o_DV;
  logic [1:0]                  o_State;

  modport master (
    output i_Binary, i_Start,
    input  o_BCD, o_Sign, o_Digits, o_Overflow, o_Busy, o_DV, o_State
  );

  modport slave (
    input  i_Binary, i_Start,
    output o_BCD, o_Sign, o_Digits, o_Overflow, o_Busy, o_DV, o_State
  );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one input bit per cycle,
// with optional two's-complement input, leading-digit count and overflow flag.
module binary_to_bcd_seq #(
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3,
  parameter bit SIGNED_MODE    = 1'b0
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  binary_to_bcd_seq_if.slave  bus
);
  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam int DIG_W = $clog2(DECIMAL_DIGITS + 1);
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]             state_q;
  logic [INPUT_WIDTH-1:0] shift_q;
  logic [BCD_W-1:0]       work_q;
  logic [BCD_W-1:0]       adj;
  logic                   ovf_q;
  logic                   sign_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [INPUT_WIDTH-1:0] mag;
  logic                   neg;
  logic [DIG_W-1:0]       digits_calc;

  // Negating the most negative value wraps to itself, which read unsigned is the
  // correct magnitude 2^(INPUT_WIDTH-1).
  always_comb begin
    neg = SIGNED_MODE && bus.i_Binary[INPUT_WIDTH-1];
    mag = neg ? -bus.i_Binary : bus.i_Binary;
  end

  always_comb begin
    adj = work_q;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (work_q[d*4 +: 4] > 4'd4)
        adj[d*4 +: 4] = work_q[d*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    digits_calc = DIG_W'(1);
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (work_q[d*4 +: 4] != 4'd0)
        digits_calc = DIG_W'(d + 1);
    end
    if (ovf_q)
      digits_calc = DIG_W'(DECIMAL_DIGITS);
  end

  assign bus.o_State = state_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q        <= S_IDLE;
      shift_q        <= '0;
      work_q         <= '0;
      ovf_q          <= 1'b0;
      sign_q         <= 1'b0;
      cnt_q          <= '0;
      bus.o_BCD      <= '0;
      bus.o_Sign     <= 1'b0;
      bus.o_Digits   <= DIG_W'(1);
      bus.o_Overflow <= 1'b0;
      bus.o_Busy     <= 1'b0;
      bus.o_DV       <= 1'b0;
    end else begin
      bus.o_DV <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_Start) begin
            shift_q    <= mag;
            sign_q     <= neg;
            work_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bus.o_Busy <= 1'b1;
            state_q    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          // A bit leaving the top digit is worth 10^DECIMAL_DIGITS: sticky overflow.
          work_q  <= {adj[BCD_W-2:0], shift_q[INPUT_WIDTH-1]};
          shift_q <= shift_q << 1;
          ovf_q   <= ovf_q | adj[BCD_W-1];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(INPUT_WIDTH - 1))
            state_q <= S_DONE;
        end
        S_DONE: begin
          bus.o_BCD      <= work_q;
          bus.o_Sign     <= sign_q;
          bus.o_Digits   <= digits_calc;
          bus.o_Overflow <= ovf_q;
          bus.o_DV       <= 1'b1;
          bus.o_Busy     <= 1'b0;
          state_q        <= S_IDLE;
        end
        default: begin
          bus.o_Busy <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Drives three converter configurations (unsigned D=3, signed D=3, unsigned D=2) with the
// same stimulus and checks every cycle against an arithmetic reference model.
module tb_binary_to_bcd_seq;
  localparam int W = 8;
  localparam logic [31:0] RST_PAT = 32'h0001_0000;

  logic       i_Clock = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bin = 8'd0;
  logic       start = 1'b0;

  always #5 i_Clock = ~i_Clock;

  binary_to_bcd_seq_if #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(3)) if0 ();
  binary_to_bcd_seq_if #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(3)) if1 ();
  binary_to_bcd_seq_if #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(2)) if2 ();

  assign if0.i_Binary = bin;
  assign if0.i_Start  = start;
  assign if1.i_Binary = bin;
  assign if1.i_Start  = start;
  assign if2.i_Binary = bin;
  assign if2.i_Start  = start;

  binary_to_bcd_seq #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(3), .SIGNED_MODE(1'b0)) u_dut0 (
    .i_Clock(i_Clock), .i_Reset(rst), .bus(if0));
  binary_to_bcd_seq #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(3), .SIGNED_MODE(1'b1)) u_dut1 (
    .i_Clock(i_Clock), .i_Reset(rst), .bus(if1));
  binary_to_bcd_seq #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(2), .SIGNED_MODE(1'b0)) u_dut2 (
    .i_Clock(i_Clock), .i_Reset(rst), .bus(if2));

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_until = 0;
  int          next_ok = 0;
  bit          armed = 1'b0;
  bit          exp_dv;
  bit          exp_busy;
  logic [7:0]  exp_q[$];
  int          due_q[$];
  logic [31:0] cur_exp [3];
  bit          sgn_cfg [3] = '{1'b0, 1'b1, 1'b0};
  int          dig_cfg [3] = '{3, 3, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Result packed as {sign[21], ovf[20], digits[19:16], bcd[15:0]}.
  function automatic logic [31:0] ref_result(input logic [7:0] b, input bit sgn, input int d);
    int          mag, lim, rem, nd, dig;
    bit          neg, ovf;
    logic [15:0] bcd;
    neg = sgn && b[7];
    mag = neg ? 256 - int'(b) : int'(b);
    lim = 10 ** d;
    ovf = (mag >= lim);
    rem = mag % lim;
    bcd = '0;
    nd  = 1;
    for (int i = 0; i < d; i++) begin
      dig = rem % 10;
      bcd[i*4 +: 4] = 4'(dig);
      if (dig != 0) nd = i + 1;
      rem = rem / 10;
    end
    if (ovf) nd = d;
    return {10'd0, neg, ovf, 4'(nd), bcd};
  endfunction

  task automatic check_dut(input int idx, input logic [15:0] bcd, input logic sign,
                           input logic [3:0] digits, input logic ovf, input logic busy,
                           input logic dv);
    check($sformatf("d%0d_dv", idx), 32'(dv), 32'(exp_dv));
    check($sformatf("d%0d_busy", idx), 32'(busy), 32'(exp_busy));
    check($sformatf("d%0d_bcd", idx), 32'(bcd), 32'(cur_exp[idx][15:0]));
    check($sformatf("d%0d_digits", idx), 32'(digits), 32'(cur_exp[idx][19:16]));
    check($sformatf("d%0d_ovf", idx), 32'(ovf), 32'(cur_exp[idx][20]));
    check($sformatf("d%0d_sign", idx), 32'(sign), 32'(cur_exp[idx][21]));
  endtask

  // Reference: a start is taken when not within W+2 cycles of the last accepted one,
  // and its result appears exactly W+1 edges later.
  always @(posedge i_Clock) begin
    cyc++;
    if (rst) begin
      armed = 1'b1;
      exp_q.delete();
      due_q.delete();
      busy_until = 0;
      next_ok = 0;
      for (int i = 0; i < 3; i++) cur_exp[i] = RST_PAT;
    end else if (start && cyc >= next_ok) begin
      exp_q.push_back(bin);
      due_q.push_back(cyc + W + 1);
      busy_until = cyc + W + 1;
      next_ok = cyc + W + 2;
    end
  end

  always @(negedge i_Clock) begin
    if (armed) begin
      exp_dv = (due_q.size() > 0) && (due_q[0] == cyc);
      if (exp_dv) begin
        for (int i = 0; i < 3; i++) cur_exp[i] = ref_result(exp_q[0], sgn_cfg[i], dig_cfg[i]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      exp_busy = (cyc < busy_until);
      check_dut(0, 16'(if0.o_BCD), if0.o_Sign, 4'(if0.o_Digits), if0.o_Overflow, if0.o_Busy, if0.o_DV);
      check_dut(1, 16'(if1.o_BCD), if1.o_Sign, 4'(if1.o_Digits), if1.o_Overflow, if1.o_Busy, if1.o_DV);
      check_dut(2, 16'(if2.o_BCD), if2.o_Sign, 4'(if2.o_Digits), if2.o_Overflow, if2.o_Busy, if2.o_DV);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic do_conv(input logic [7:0] v);
    bin = v;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    bin = 8'($urandom);
    tick(W + 2);
  endtask

  logic [7:0] dir_vals [10] = '{8'd255, 8'hFF, 8'h80, 8'h00, 8'd200, 8'd99,
                                8'd1, 8'd100, 8'd10, 8'h7F};

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    foreach (dir_vals[i]) do_conv(dir_vals[i]);

    // Second start while busy must be dropped.
    bin = 8'd42; start = 1'b1; tick(1);
    start = 1'b0; tick(2);
    bin = 8'd7; start = 1'b1; tick(1);
    start = 1'b0; tick(W + 2);

    // Reset mid-conversion, then restart.
    bin = 8'd200; start = 1'b1; tick(1);
    start = 1'b0; tick(3);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(1);
    bin = 8'd10; start = 1'b1; tick(1);
    start = 1'b0; tick(W + 2);

    // Start held high: back-to-back conversions.
    start = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      bin = 8'(v);
      tick(W + 2);
    end
    start = 1'b0;
    tick(W + 2);

    repeat (600) begin
      bin   = 8'($urandom_range(0, 255));
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    rst = 1'b0;
    start = 1'b0;
    tick(W + 4);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter INPUT_WIDTH, default 8, binary input width, legal range 2..32.
REQ-002 The block SHALL have parameter DECIMAL_DIGITS, default 3, number of BCD output digits, legal range 1..10.
REQ-003 The block SHALL have parameter SIGNED_MODE, default 0: 0 = i_Binary unsigned; 1 = i_Binary two's complement.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 i_Clock  input  1  rising-edge clock for all state.
REQ-006 i_Reset  input  1  synchronous active-high reset.
REQ-007 i_Binary  input  INPUT_WIDTH  value to convert, sampled only when a start is accepted.
REQ-008 i_Start  input  1  conversion request, level-sampled each rising edge.
REQ-009 o_BCD  output  DECIMAL_DIGITS*4  magnitude in BCD, digit 0 = bits [3:0].
REQ-010 o_Sign  output  1  1 = result negative (SIGNED_MODE=1 only, else constant 0).
REQ-011 o_Digits  output  $clog2(DECIMAL_DIGITS+1)  count of significant digits, leading zeros excluded, minimum 1.
REQ-012 o_Overflow  output  1  magnitude >= 10^DECIMAL_DIGITS.
REQ-013 o_Busy  output  1  conversion in progress; starts ignored while high.
REQ-014 o_DV  output  1  one-cycle pulse marking new result on o_BCD/o_Sign/o_Digits/o_Overflow.

Function
REQ-015 The FSM SHALL have states IDLE, CONVERT, DONE; encoding is free; illegal states SHALL return to IDLE on the next edge.
REQ-016 In IDLE with i_Start=1 at edge k: capture magnitude of i_Binary into the shift register, clear working BCD, overflow flag and bit counter, go to CONVERT; o_Busy=1 from edge k.
REQ-017 Magnitude: SIGNED_MODE=0 -> i_Binary as is; SIGNED_MODE=1 and MSB=1 -> two's-complement negation in INPUT_WIDTH bits, read as unsigned (so -2^(INPUT_WIDTH-1) yields 2^(INPUT_WIDTH-1)); captured sign stored.
REQ-018 Each CONVERT edge SHALL, in one cycle, add 3 to every working digit > 4 (all digits in parallel), then shift working BCD left by 1, inserting the shift register MSB at bit 0; shift register shifts left by 1.
REQ-019 A 1 shifted out of the top BCD bit SHALL set the sticky overflow flag; remaining digits SHALL equal magnitude mod 10^DECIMAL_DIGITS.
REQ-020 After exactly INPUT_WIDTH CONVERT edges (edges k+1..k+INPUT_WIDTH) the FSM SHALL enter DONE.
REQ-021 At edge k+INPUT_WIDTH+1 (DONE) the block SHALL update o_BCD, o_Sign, o_Overflow, o_Digits, pulse o_DV=1 for one cycle, clear o_Busy, return to IDLE.
REQ-022 Latency: o_DV high in the cycle following edge k+INPUT_WIDTH+1; next start accepted at edge k+INPUT_WIDTH+2 earliest, giving back-to-back throughput of one result per INPUT_WIDTH+2 cycles.
REQ-023 o_Digits = index of highest nonzero digit + 1; zero magnitude -> 1; o_Overflow=1 -> DECIMAL_DIGITS.
REQ-024 o_Sign SHALL be 0 when magnitude is zero.
REQ-025 i_Start while o_Busy=1 SHALL be ignored, not queued; i_Binary changes during conversion SHALL not affect the result.
REQ-026 i_Start held high continuously SHALL start a new conversion at each IDLE edge.
REQ-027 Result outputs SHALL hold their last values between o_DV pulses.

Reset
REQ-028 i_Reset=1 at any edge, including mid-CONVERT or DONE, SHALL force IDLE, abort conversion, and set o_BCD=0, o_Sign=0, o_Digits=1, o_Overflow=0, o_Busy=0, o_DV=0.
REQ-029 i_Reset SHALL take priority over i_Start on the same edge; first start is accepted at the first edge with i_Reset=0.

Verification
REQ-030 Unsigned W=8,D=3: i_Binary=8'd255, start at edge k -> o_DV in cycle after edge k+9, o_BCD=12'h255, o_Digits=3, o_Overflow=0.
REQ-031 SIGNED_MODE=1,W=8,D=3: 8'hFF -> o_Sign=1, o_BCD=12'h001, o_Digits=1; 8'h80 -> o_Sign=1, o_BCD=12'h128; 8'h00 -> o_Sign=0, o_BCD=0, o_Digits=1.
REQ-032 Unsigned W=8,D=2: 8'd200 -> o_Overflow=1, o_BCD=8'h00, o_Digits=2; 8'd99 -> o_Overflow=0, o_BCD=8'h99.
REQ-033 Start 8'd42, pulse i_Start with 8'd7 at edge k+3 -> single o_DV, o_BCD=12'h042, no second result.
REQ-034 Reset at edge k+4 mid-conversion -> all outputs at reset values next cycle, no o_DV; new start at edge k+6 with 8'd10 -> o_BCD=12'h010 at edge k+15.
REQ-035 i_Start held high, inputs 1,2,3 per accepted start -> o_DV every 10 cycles with o_BCD 001, 002, 003.
